instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Program store that sits on the instruction side of the 8-bit microprocessor.
- Load mode: accepts a byte stream through a valid/ready handshake and writes it to consecutive addresses starting at 0.
- Run mode: takes the processor's 8-bit pc and returns the stored instruction byte with one cycle of latency.
- Any address at or beyond the loaded program length reads back a fill instruction, so the core never executes stale or uninitialised contents.

Parameters:
- DEPTH, 256, number of instruction bytes stored (1..256).
- FILL_INST, 8'h00, instruction returned for any pc at or beyond programLength, and in IDLE or LOAD.

Ports:
- clk  input  1  system clock (the divided processor clock); all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- loadStart  input  1  single-cycle request to begin or restart loading.
- loadValid  input  1  loadData holds a valid byte.
- loadData  input  8  instruction byte to store.
- loadLast  input  1  qualifies the current loadValid beat as the final byte.
- loadReady  output  1  block accepts a byte this cycle.
- pc  input  8  fetch address from the processor.
- instruction  output  8  registered instruction byte.
- instValid  output  1  instruction is meaningful (RUN only).
- programLength  output  9  number of bytes loaded (0..DEPTH).
- state  output  2  current state: 00 IDLE, 01 LOAD, 10 RUN.
- loadError  output  1  sticky flag: memory filled without loadLast.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wrPtr=0, programLength=0.
  - instruction=FILL_INST; instValid=0, loadReady=0, loadError=0.
  - Array contents are not cleared. They are unreachable because programLength=0.
- IDLE:
  - loadStart=1 -> LOAD next edge; wrPtr=0, programLength=0, loadError=0.
  - loadValid is ignored.
- LOAD:
  - loadReady=1 combinationally while in LOAD.
  - Accepted beat = loadValid & loadReady. On that edge: mem[wrPtr]<=loadData, wrPtr+1, programLength+1.
  - Accepted beat with loadLast=1 -> RUN.
  - Accepted beat at wrPtr=DEPTH-1 with loadLast=0 -> RUN, loadError<=1.
  - Accepted beat at wrPtr=DEPTH-1 with loadLast=1 -> RUN, no error.
  - loadLast without loadValid is ignored. loadStart is ignored in LOAD. No beat is ever written at or beyond DEPTH.
  - Output during LOAD: instruction=FILL_INST, instValid=0.
- RUN:
  - Each edge: instruction <= (pc < programLength) ? mem[pc] : FILL_INST. The comparison uses the 9-bit zero-extended pc.
  - Latency is one cycle from pc to instruction.
  - The first edge in RUN performs the first fetch. instValid=1 from that edge onward.
  - loadValid is ignored and loadReady=0.
  - loadStart=1 -> LOAD next edge: wrPtr and programLength cleared, loadError cleared, instValid<=0, instruction<=FILL_INST.
- No simultaneous read/write hazards: reads occur only in RUN and writes only in LOAD.
- Reset asserted mid-LOAD aborts the load immediately. programLength=0 after release, so all reads return FILL_INST until a new load completes.
- pc >= DEPTH (when DEPTH<256) always returns FILL_INST.

Test Plan:
- Reset, then loadStart; stream 8'h41, 8'h52, 8'h63 with loadLast on the third byte -> state LOAD then RUN, programLength=3. pc=0,1,2 gives 41,52,63 one cycle later; pc=3 gives 00; instValid=1.
- Back-to-back beats with loadValid held high and gaps where loadValid=0 -> only valid beats are written, programLength counts exactly the accepted beats, and loadReady=1 throughout LOAD.
- DEPTH=4, load 4 bytes without loadLast -> RUN after the 4th beat, loadError=1, programLength=4. Repeat with loadLast on the 4th beat -> loadError=0.
- In RUN with a 3-byte program, pulse loadStart and load 1 byte 8'hAA -> instValid drops and programLength=1. pc=0 returns AA; pc=1 returns 00, the old contents being hidden.
- Assert reset mid-LOAD after 2 beats -> all outputs return to reset values immediately (asynchronously). After release, state=IDLE, programLength=0, instruction=00.
- In IDLE and RUN, drive loadValid=1 with data -> no write occurs and programLength is unchanged.

Source files
------------

// File: rtl/instruction_memory.sv
// Instruction-side program store for the 8-bit core: streamed load through a
// valid/ready handshake, then registered single-cycle fetch guarded by programLength.
module instruction_memory #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] FILL_INST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadStart,
    input  logic       loadValid,
    input  logic [7:0] loadData,
    input  logic       loadLast,
    output logic       loadReady,
    input  logic [7:0] pc,
    output logic [7:0] instruction,
    output logic       instValid,
    output logic [8:0] programLength,
    output logic [1:0] state,
    output logic       loadError
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } stateType;

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] LAST_IDX = 9'(DEPTH - 1);

    stateType      curState;
    stateType      nextState;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdAddr;
    logic          beat;
    logic          lastSlot;
    logic          fetchHit;

    // The write pointer is always equal to the count of bytes accepted so far.
    assign wrPtr     = programLength[AW-1:0];
    assign rdAddr    = pc[AW-1:0];
    assign loadReady = (curState == LOAD);
    assign beat      = loadValid && loadReady;
    assign lastSlot  = (programLength == LAST_IDX);
    assign fetchHit  = ({1'b0, pc} < programLength);
    assign state     = curState;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) curState <= IDLE;
        else        curState <= nextState;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        nextState = curState;
        case (curState)
            IDLE:    if (loadStart) nextState = LOAD;
            LOAD:    if (beat && (loadLast || lastSlot)) nextState = RUN;
            RUN:     if (loadStart) nextState = LOAD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            programLength <= '0;
            instruction   <= FILL_INST;
            instValid     <= 1'b0;
            loadError     <= 1'b0;
        end else begin
            case (curState)
                IDLE: begin
                    if (loadStart) begin
                        programLength <= '0;
                        loadError     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        programLength <= programLength + 9'd1;
                        if (lastSlot && !loadLast) loadError <= 1'b1;
                    end
                end
                RUN: begin
                    if (loadStart) begin
                        programLength <= '0;
                        loadError     <= 1'b0;
                        instValid     <= 1'b0;
                        instruction   <= FILL_INST;
                    end else begin
                        // Anything past the loaded program reads as fill, hiding stale bytes.
                        instruction <= fetchHit ? mem[rdAddr] : FILL_INST;
                        instValid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset; programLength=0 makes every old byte unreachable.
    always_ff @(posedge clk) begin
        if (beat) mem[wrPtr] <= loadData;
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: randomized loads and fetches compared
// against a queue-based model of the loaded program.
module tb_instruction_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic       loadStart, loadValid, loadLast;
    logic [7:0] loadData, pc;
    logic       loadReady, instValid, loadError;
    logic [7:0] instruction;
    logic [8:0] programLength;
    logic [1:0] state;

    logic       sLoadStart, sLoadValid, sLoadLast;
    logic [7:0] sLoadData, sPc;
    logic       sLoadReady, sInstValid, sLoadError;
    logic [7:0] sInstruction;
    logic [8:0] sProgramLength;
    logic [1:0] sState;

    int total = 0;
    int bad   = 0;
    logic [7:0] prog[$];
    logic [7:0] stim[$];

    always #5 clk = ~clk;

    instruction_memory dut (
        .clk(clk), .reset(reset), .loadStart(loadStart), .loadValid(loadValid),
        .loadData(loadData), .loadLast(loadLast), .loadReady(loadReady), .pc(pc),
        .instruction(instruction), .instValid(instValid), .programLength(programLength),
        .state(state), .loadError(loadError)
    );

    instruction_memory #(.DEPTH(4), .FILL_INST(8'h00)) dut4 (
        .clk(clk), .reset(reset), .loadStart(sLoadStart), .loadValid(sLoadValid),
        .loadData(sLoadData), .loadLast(sLoadLast), .loadReady(sLoadReady), .pc(sPc),
        .instruction(sInstruction), .instValid(sInstValid), .programLength(sProgramLength),
        .state(sState), .loadError(sLoadError)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchCheck(input logic [7:0] p, input logic holdValid);
        logic [7:0] exp;
        exp = (int'(p) < prog.size()) ? prog[p] : 8'h00;
        pc        = p;
        loadValid = holdValid;
        loadData  = 8'($urandom);
        tick();
        total++; if (instruction !== exp) begin bad++; $display("FAIL fetch pc=%0d got=%02h exp=%02h", p, instruction, exp); end
        total++; if (instValid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%0b exp=1", instValid); end
        total++; if (loadReady !== 1'b0) begin bad++; $display("FAIL run_ready got=%0b exp=0", loadReady); end
        total++; if (programLength !== 9'(prog.size())) begin bad++; $display("FAIL run_len got=%0d exp=%0d", programLength, prog.size()); end
    endtask

    task automatic randomFetches(input int n, input logic holdValid);
        for (int i = 0; i < n; i++) begin
            int hi;
            hi = prog.size() + 3;
            if (hi > 255) hi = 255;
            fetchCheck(8'($urandom_range(0, hi)), holdValid);
        end
        loadValid = 1'b0;
    endtask

    // Loads the bytes in stim; the model program becomes exactly the accepted bytes.
    task automatic loadProgram(input logic withLast);
        int  n;
        logic expRun;
        n = stim.size();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        total++; if (state !== 2'b01) begin bad++; $display("FAIL load_enter state got=%0d exp=1", state); end
        total++; if (programLength !== 9'd0) begin bad++; $display("FAIL load_clear_len got=%0d exp=0", programLength); end
        total++; if (loadError !== 1'b0) begin bad++; $display("FAIL load_clear_err got=%0b exp=0", loadError); end
        total++; if (instValid !== 1'b0 || instruction !== 8'h00) begin bad++; $display("FAIL load_outputs valid=%0b inst=%02h exp 0/00", instValid, instruction); end
        prog.delete();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                loadValid = 1'b0;
                loadLast  = 1'($urandom);
                loadData  = 8'($urandom);
                tick();
                total++; if (loadReady !== 1'b1 || programLength !== 9'(prog.size())) begin bad++; $display("FAIL gap ready=%0b len=%0d exp 1/%0d", loadReady, programLength, prog.size()); end
            end
            loadValid = 1'b1;
            loadData  = stim[i];
            loadLast  = withLast && (i == n - 1);
            total++; if (loadReady !== 1'b1) begin bad++; $display("FAIL beat_ready got=%0b exp=1", loadReady); end
            tick();
            prog.push_back(stim[i]);
            if (i < n - 1) begin
                total++; if (state !== 2'b01 || programLength !== 9'(i + 1)) begin bad++; $display("FAIL beat state=%0d len=%0d exp 1/%0d", state, programLength, i + 1); end
            end
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        expRun = withLast || (n == 256);
        total++; if (programLength !== 9'(n)) begin bad++; $display("FAIL load_len got=%0d exp=%0d", programLength, n); end
        total++; if (state !== (expRun ? 2'b10 : 2'b01)) begin bad++; $display("FAIL load_done state got=%0d exp=%0d", state, expRun ? 2 : 1); end
        total++; if (loadError !== (n == 256 && !withLast)) begin bad++; $display("FAIL load_err got=%0b exp=%0b", loadError, n == 256 && !withLast); end
        total++; if (instValid !== 1'b0 || instruction !== 8'h00) begin bad++; $display("FAIL pre_fetch valid=%0b inst=%02h exp 0/00", instValid, instruction); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {loadStart, loadValid, loadLast, loadData, pc} = '0;
        {sLoadStart, sLoadValid, sLoadLast, sLoadData, sPc} = '0;
        #12;
        total++; if (state !== 2'b00 || programLength !== 9'd0) begin bad++; $display("FAIL reset state=%0d len=%0d exp 0/0", state, programLength); end
        total++; if (instruction !== 8'h00 || instValid !== 1'b0) begin bad++; $display("FAIL reset inst=%02h valid=%0b exp 00/0", instruction, instValid); end
        total++; if (loadReady !== 1'b0 || loadError !== 1'b0) begin bad++; $display("FAIL reset ready=%0b err=%0b exp 0/0", loadReady, loadError); end
        #1 reset = 1'b1;
        tick();
        prog.delete();
        for (int i = 0; i < 3; i++) begin
            loadValid = 1'b1;
            loadLast  = 1'b1;
            loadData  = 8'($urandom);
            tick();
            total++; if (state !== 2'b00 || programLength !== 9'd0 || loadReady !== 1'b0) begin bad++; $display("FAIL idle_ignore state=%0d len=%0d ready=%0b exp 0/0/0", state, programLength, loadReady); end
        end
        {loadValid, loadLast} = '0;
    endtask

    task automatic test_basic();
        stim = '{8'h41, 8'h52, 8'h63};
        loadProgram(1'b1);
        for (int p = 0; p < 4; p++) fetchCheck(8'(p), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            stim.delete();
            repeat ($urandom_range(5, 24)) stim.push_back(8'($urandom));
            loadProgram(1'b1);
            randomFetches(20, 1'b0);
        end
    endtask

    task automatic test_ignore_run();
        randomFetches(10, 1'b1);
        randomFetches(10, 1'b0);
    endtask

    task automatic test_reload();
        stim = '{8'h10, 8'h20, 8'h30};
        loadProgram(1'b1);
        randomFetches(4, 1'b0);
        stim = '{8'hAA};
        loadProgram(1'b1);
        for (int p = 0; p < 3; p++) fetchCheck(8'(p), 1'b0);
    endtask

    task automatic test_full_depth();
        stim.delete();
        repeat (256) stim.push_back(8'($urandom));
        loadProgram(1'b0);
        fetchCheck(8'd255, 1'b0);
        fetchCheck(8'd0, 1'b0);
        for (int i = 0; i < 8; i++) fetchCheck(8'($urandom), 1'b0);
    endtask

    task automatic test_reset_mid_load();
        loadStart = 1'b1;
        tick();
        loadStart = 1'b0;
        loadValid = 1'b1;
        loadData  = 8'h5A;
        tick();
        loadData  = 8'hA5;
        tick();
        total++; if (programLength !== 9'd2 || state !== 2'b01) begin bad++; $display("FAIL mid_load len=%0d state=%0d exp 2/1", programLength, state); end
        #2 reset = 1'b0;
        #1;
        total++; if (state !== 2'b00 || programLength !== 9'd0 || loadReady !== 1'b0) begin bad++; $display("FAIL async_reset state=%0d len=%0d ready=%0b exp 0/0/0", state, programLength, loadReady); end
        total++; if (instruction !== 8'h00 || instValid !== 1'b0 || loadError !== 1'b0) begin bad++; $display("FAIL async_reset inst=%02h valid=%0b err=%0b exp 00/0/0", instruction, instValid, loadError); end
        loadValid = 1'b0;
        #3 reset = 1'b1;
        tick();
        tick();
        total++; if (state !== 2'b00 || programLength !== 9'd0 || instruction !== 8'h00) begin bad++; $display("FAIL after_reset state=%0d len=%0d inst=%02h exp 0/0/00", state, programLength, instruction); end
        prog.delete();
        stim = '{8'h77};
        loadProgram(1'b1);
        for (int p = 0; p < 3; p++) fetchCheck(8'(p), 1'b0);
    endtask

    task automatic test_depth4();
        logic [7:0] d[4];
        for (int r = 0; r < 2; r++) begin
            logic withLast;
            withLast   = (r == 1);
            sLoadStart = 1'b1;
            tick();
            sLoadStart = 1'b0;
            total++; if (sState !== 2'b01 || sLoadError !== 1'b0 || sProgramLength !== 9'd0) begin bad++; $display("FAIL d4_start state=%0d err=%0b len=%0d exp 1/0/0", sState, sLoadError, sProgramLength); end
            for (int i = 0; i < 4; i++) begin
                d[i]       = 8'($urandom);
                sLoadValid = 1'b1;
                sLoadData  = d[i];
                sLoadLast  = withLast && (i == 3);
                total++; if (sLoadReady !== 1'b1) begin bad++; $display("FAIL d4_ready got=%0b exp=1", sLoadReady); end
                tick();
            end
            {sLoadValid, sLoadLast} = '0;
            total++; if (sState !== 2'b10 || sProgramLength !== 9'd4) begin bad++; $display("FAIL d4_done state=%0d len=%0d exp 2/4", sState, sProgramLength); end
            total++; if (sLoadError !== !withLast) begin bad++; $display("FAIL d4_err got=%0b exp=%0b", sLoadError, !withLast); end
            total++; if (sLoadReady !== 1'b0) begin bad++; $display("FAIL d4_run_ready got=%0b exp=0", sLoadReady); end
            for (int k = 0; k < 12; k++) begin
                logic [7:0] p, exp;
                p   = (k < 8) ? 8'(k) : 8'($urandom);
                exp = (p < 4) ? d[p[1:0]] : 8'h00;
                sPc = p;
                tick();
                total++; if (sInstruction !== exp || sInstValid !== 1'b1) begin bad++; $display("FAIL d4_fetch pc=%0d got=%02h/%0b exp=%02h/1", p, sInstruction, sInstValid, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_run();
        test_reload();
        test_full_depth();
        test_reset_mid_load();
        test_depth4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
